// File: rtl/time_frame_pkg.sv
// Frame definition shared by the time-digit multiplexer and its deframer:
// separator/fault codes, nibble positions and the acquisition states.
package time_frame_pkg;

   localparam logic [3:0] SEP       = 4'd10;
   localparam logic [3:0] FAULT     = 4'd12;
   localparam int         FRAME_LEN = 8;
   localparam int         POS_W     = $clog2(FRAME_LEN);

   localparam logic [POS_W-1:0] POS_MS_LO  = 3'd0;
   localparam logic [POS_W-1:0] POS_MS_HI  = 3'd1;
   localparam logic [POS_W-1:0] POS_SEP0   = 3'd2;
   localparam logic [POS_W-1:0] POS_S_LO   = 3'd3;
   localparam logic [POS_W-1:0] POS_S_HI   = 3'd4;
   localparam logic [POS_W-1:0] POS_SEP1   = 3'd5;
   localparam logic [POS_W-1:0] POS_MIN_LO = 3'd6;
   localparam logic [POS_W-1:0] POS_MIN_HI = 3'd7;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_GAP,
      ST_CONFIRM,
      ST_LOCK
   } frame_state_t;

   typedef struct packed {
      logic [7:0] ms;
      logic [7:0] sec;
      logic [7:0] mins;
   } time_bcd_t;

   function automatic logic is_sep_pos(input logic [POS_W-1:0] pos);
      return (pos == POS_SEP0) || (pos == POS_SEP1);
   endfunction

endpackage

// File: rtl/bcd_nibble_check.sv
// Flags a nibble that does not belong at its frame position; combinational.
// Backpressure: none.
module bcd_nibble_check
   import time_frame_pkg::*;
(
   input  logic [3:0]       nibble,
   input  logic [POS_W-1:0] pos,
   output logic             bad
);

   // The fault code is already out of BCD range; it is named so the intent is visible.
   always_comb begin
      if (is_sep_pos(pos)) begin
         bad = (nibble != SEP);
      end else begin
         bad = (nibble > 4'd9) || (nibble == FAULT);
      end
   end

endmodule

// File: rtl/time_stream_deframer.sv
// Aligns to the 8-nibble time stream and commits {ms,s,min} BCD snapshots; commit on the min_hi sample.
// Backpressure: none, one nibble is consumed every clkc cycle.
module time_stream_deframer
   import time_frame_pkg::*;
#(
   parameter int MISS_MAX = 2
) (
   input  logic       clkc,
   input  logic       rst,
   input  logic [3:0] inc,
   output logic [7:0] out_ms,
   output logic [7:0] out_s,
   output logic [7:0] out_min,
   output logic       frame_valid,
   output logic       locked,
   output logic       err
);

   localparam int                MISS_W      = $clog2(MISS_MAX + 1);
   localparam logic [MISS_W-1:0] MISS_LAST   = MISS_W'(MISS_MAX - 1);
   localparam logic [2:0]        GAP_CONFIRM = 3'd2;
   localparam logic [2:0]        GAP_GIVE_UP = 3'd6;

   frame_state_t      state, state_nxt;
   logic [POS_W-1:0]  pos, pos_nxt, chk_pos;
   logic [2:0]        gap, gap_nxt;
   logic [MISS_W-1:0] miss, miss_nxt;
   logic              frame_bad, frame_bad_nxt;

   logic              nib_bad;
   logic              is_sep;
   logic              tracking;
   logic              err_hit;
   logic              commit;
   logic              cap_ms_lo, cap_ms_hi, cap_s_lo, cap_s_hi, cap_min_lo;

   logic [3:0]        sh_ms_lo, sh_ms_hi, sh_s_lo, sh_s_hi, sh_min_lo;
   time_bcd_t         snap;

   // pos holds the position of the last accepted nibble, so the incoming one sits at pos+1.
   assign chk_pos = pos + 3'd1;
   assign is_sep  = (inc == SEP);

   bcd_nibble_check u_check (
      .nibble (inc),
      .pos    (chk_pos),
      .bad    (nib_bad)
   );

   always_ff @(posedge clkc) begin
      if (rst) begin
         state     <= ST_HUNT;
         pos       <= '0;
         gap       <= '0;
         miss      <= '0;
         frame_bad <= 1'b0;
      end else begin
         state     <= state_nxt;
         pos       <= pos_nxt;
         gap       <= gap_nxt;
         miss      <= miss_nxt;
         frame_bad <= frame_bad_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pos_nxt       = pos;
      gap_nxt       = gap;
      miss_nxt      = miss;
      frame_bad_nxt = frame_bad;
      unique case (state)
         ST_HUNT: begin
            if (is_sep) begin
               state_nxt = ST_GAP;
               gap_nxt   = '0;
            end
         end
         ST_GAP: begin
            // Separators three cycles apart can only be pos 2 then pos 5.
            if (is_sep) begin
               if (gap == GAP_CONFIRM) begin
                  state_nxt = ST_CONFIRM;
                  pos_nxt   = POS_SEP1;
               end
               gap_nxt = '0;
            end else if (gap == GAP_GIVE_UP) begin
               state_nxt = ST_HUNT;
               gap_nxt   = '0;
            end else begin
               gap_nxt = gap + 3'd1;
            end
         end
         ST_CONFIRM: begin
            pos_nxt = chk_pos;
            if (nib_bad) begin
               state_nxt = ST_HUNT;
               pos_nxt   = '0;
            end else if (chk_pos == POS_SEP0) begin
               state_nxt     = ST_LOCK;
               frame_bad_nxt = 1'b0;
               miss_nxt      = '0;
            end
         end
         ST_LOCK: begin
            pos_nxt = chk_pos;
            if (nib_bad) begin
               frame_bad_nxt = 1'b1;
            end
            if (chk_pos == POS_MIN_HI) begin
               frame_bad_nxt = 1'b0;
               if (!frame_bad && !nib_bad) begin
                  miss_nxt = '0;
               end else if (miss == MISS_LAST) begin
                  state_nxt = ST_HUNT;
                  miss_nxt  = '0;
                  pos_nxt   = '0;
               end else begin
                  miss_nxt = miss + MISS_W'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_HUNT;
         end
      endcase
   end

   always_comb begin
      tracking   = (state == ST_CONFIRM) || (state == ST_LOCK);
      err_hit    = tracking && nib_bad;
      commit     = (state == ST_LOCK) && (chk_pos == POS_MIN_HI) && !frame_bad && !nib_bad;
      cap_ms_lo  = tracking && (chk_pos == POS_MS_LO);
      cap_ms_hi  = tracking && (chk_pos == POS_MS_HI);
      cap_s_lo   = tracking && (chk_pos == POS_S_LO);
      cap_s_hi   = tracking && (chk_pos == POS_S_HI);
      cap_min_lo = tracking && (chk_pos == POS_MIN_LO);
   end

   always_ff @(posedge clkc) begin
      if (rst) begin
         sh_ms_lo    <= '0;
         sh_ms_hi    <= '0;
         sh_s_lo     <= '0;
         sh_s_hi     <= '0;
         sh_min_lo   <= '0;
         snap        <= '0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (cap_ms_lo)  sh_ms_lo  <= inc;
         if (cap_ms_hi)  sh_ms_hi  <= inc;
         if (cap_s_lo)   sh_s_lo   <= inc;
         if (cap_s_hi)   sh_s_hi   <= inc;
         if (cap_min_lo) sh_min_lo <= inc;
         // min_hi is taken straight from the bus so the commit lands on its own sample.
         if (commit) begin
            snap.ms   <= {sh_ms_hi, sh_ms_lo};
            snap.sec  <= {sh_s_hi, sh_s_lo};
            snap.mins <= {inc, sh_min_lo};
         end
         frame_valid <= commit;
         locked      <= (state_nxt == ST_LOCK);
         err         <= err_hit;
      end
   end

   assign out_ms  = snap.ms;
   assign out_s   = snap.sec;
   assign out_min = snap.mins;

endmodule

// File: tb/tb_time_stream_deframer.sv
// Bench for time_stream_deframer: stream tasks against a timestamp/history reference model.
module tb_time_stream_deframer;

   logic       clkc = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] inc  = 4'd0;
   logic [7:0] out_ms, out_s, out_min;
   logic       frame_valid, locked, err;

   int checks   = 0;
   int failures = 0;

   time_stream_deframer #(.MISS_MAX(2)) dut (
      .clkc        (clkc),
      .rst         (rst),
      .inc         (inc),
      .out_ms      (out_ms),
      .out_s       (out_s),
      .out_min     (out_min),
      .frame_valid (frame_valid),
      .locked      (locked),
      .err         (err)
   );

   always #5 clkc = ~clkc;

   // Reference model: remembers when separators were seen and reads digits from stream history.
   logic [3:0]  hist [0:4095];
   int          t = 0;
   int          sp = 0;
   int          m_sep_t, m_conf_t, m_base, m_miss;
   bit          m_lk, m_fbad, m_fv, m_err;
   logic [23:0] m_out;

   function automatic bit nib_bad(input logic [3:0] n, input int p);
      if (p == 2 || p == 5) return n != 4'd10;
      return n > 4'd9;
   endfunction

   function automatic logic [3:0] h_at(input int i);
      return hist[i & 4095];
   endfunction

   function automatic logic [3:0] frame_nib(input logic [23:0] v, input int p);
      case (p)
         0:       return v[19:16];
         1:       return v[23:20];
         2, 5:    return 4'd10;
         3:       return v[11:8];
         4:       return v[15:12];
         6:       return v[3:0];
         default: return v[7:4];
      endcase
   endfunction

   function automatic logic [23:0] rand_time();
      logic [23:0] r;
      r[23:20] = 4'($urandom_range(0, 9));
      r[19:16] = 4'($urandom_range(0, 9));
      r[15:12] = 4'($urandom_range(0, 5));
      r[11:8]  = 4'($urandom_range(0, 9));
      r[7:4]   = 4'($urandom_range(0, 5));
      r[3:0]   = 4'($urandom_range(0, 9));
      return r;
   endfunction

   task automatic model_reset();
      m_sep_t = -1; m_conf_t = -1; m_base = 0; m_miss = 0;
      m_lk = 0; m_fbad = 0; m_fv = 0; m_err = 0; m_out = '0;
   endtask

   task automatic model_step(input logic [3:0] n);
      int p, k, d;
      hist[t & 4095] = n;
      m_fv  = 0;
      m_err = 0;
      if (m_lk) begin
         p = (t - m_base) % 8;
         if (nib_bad(n, p)) begin m_err = 1; m_fbad = 1; end
         if (p == 7) begin
            if (!m_fbad) begin
               m_out  = {h_at(t-6), h_at(t-7), h_at(t-3), h_at(t-4), n, h_at(t-1)};
               m_fv   = 1;
               m_miss = 0;
            end else begin
               m_miss++;
               if (m_miss >= 2) begin m_lk = 0; m_sep_t = -1; m_conf_t = -1; end
            end
            m_fbad = 0;
         end
      end else if (m_conf_t >= 0) begin
         k = t - m_conf_t;
         p = (5 + k) % 8;
         if (nib_bad(n, p)) begin
            m_err = 1; m_conf_t = -1; m_sep_t = -1;
         end else if (k == 5) begin
            m_lk = 1; m_base = t - 2; m_fbad = 0; m_miss = 0; m_conf_t = -1;
         end
      end else if (m_sep_t >= 0) begin
         d = t - m_sep_t;
         if (n == 4'd10) begin
            if (d == 3) begin m_conf_t = t; m_sep_t = -1; end
            else m_sep_t = t;
         end else if (d >= 7) begin
            m_sep_t = -1;
         end
      end else if (n == 4'd10) begin
         m_sep_t = t;
      end
      t++;
   endtask

   task automatic src(input logic [3:0] n);
      inc = n;
      @(posedge clkc);
      #1;
      model_step(n);
      sp = (sp + 1) % 8;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      inc = 4'd0;
      @(posedge clkc);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inc = 4'($urandom_range(0, 15));
         @(posedge clkc);
         #1;
         checks++;
         if ({out_ms, out_s, out_min, frame_valid, locked, err} !== 27'd0) begin
            failures++;
            $display("FAIL reset_state cycle=%0d got=%h want=0", i, {out_ms, out_s, out_min, frame_valid, locked, err});
         end
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_clean_acquisition();
      logic [23:0] v = 24'h473205;
      int first_lock = -1;
      pulse_reset();
      sp = 0;
      for (int s = 0; s < 48; s++) begin
         src(frame_nib(v, sp));
         checks++;
         if ({out_ms, out_s, out_min, frame_valid, locked, err} !== {m_out, m_fv, m_lk, m_err}) begin
            failures++;
            $display("FAIL clean_cycle s=%0d got=%h want=%h", s, {out_ms, out_s, out_min, frame_valid, locked, err}, {m_out, m_fv, m_lk, m_err});
         end
         if (locked === 1'b1 && first_lock < 0) first_lock = s;
         if (s == 14) begin
            checks++;
            if (frame_valid !== 1'b0 || {out_ms, out_s, out_min} !== 24'h0) begin
               failures++;
               $display("FAIL clean_precommit got fv=%b out=%h want fv=0 out=0", frame_valid, {out_ms, out_s, out_min});
            end
         end
         if (s >= 15 && s % 8 == 7) begin
            checks++;
            if (frame_valid !== 1'b1 || {out_ms, out_s, out_min} !== 24'h473205) begin
               failures++;
               $display("FAIL clean_commit s=%0d got fv=%b out=%h want fv=1 out=473205", s, frame_valid, {out_ms, out_s, out_min});
            end
         end
      end
      checks++;
      if (first_lock != 10) begin
         failures++;
         $display("FAIL clean_lock_time got=%0d want=10", first_lock);
      end
   endtask

   task automatic test_mid_frame();
      logic [23:0] v = rand_time();
      logic [23:0] first_val = '0;
      int first_lock = -1;
      int first_fv = -1;
      pulse_reset();
      sp = 4;
      for (int s = 0; s < 44; s++) begin
         src(frame_nib(v, sp));
         checks++;
         if ({out_ms, out_s, out_min, frame_valid, locked, err} !== {m_out, m_fv, m_lk, m_err}) begin
            failures++;
            $display("FAIL midframe_cycle s=%0d got=%h want=%h", s, {out_ms, out_s, out_min, frame_valid, locked, err}, {m_out, m_fv, m_lk, m_err});
         end
         if (locked === 1'b1 && first_lock < 0) first_lock = s;
         if (frame_valid === 1'b1 && first_fv < 0) begin
            first_fv  = s;
            first_val = {out_ms, out_s, out_min};
         end
      end
      checks++;
      if (first_lock != 14) begin
         failures++;
         $display("FAIL midframe_lock_time got=%0d want=14", first_lock);
      end
      checks++;
      if (first_fv != 19 || first_val !== v) begin
         failures++;
         $display("FAIL midframe_first_commit got s=%0d val=%h want s=19 val=%h", first_fv, first_val, v);
      end
   endtask

   task automatic test_glitch();
      logic [23:0] vf [3];
      logic [3:0] n;
      int err_cnt = 0;
      int unlocked = 0;
      for (int f = 0; f < 3; f++) vf[f] = rand_time();
      for (int f = 0; f < 3; f++) begin
         for (int p = 0; p < 8; p++) begin
            n = frame_nib(vf[f], sp);
            if (f == 1 && p == 3) n = 4'd12;
            src(n);
            checks++;
            if ({out_ms, out_s, out_min, frame_valid, locked, err} !== {m_out, m_fv, m_lk, m_err}) begin
               failures++;
               $display("FAIL glitch_cycle f=%0d p=%0d got=%h want=%h", f, p, {out_ms, out_s, out_min, frame_valid, locked, err}, {m_out, m_fv, m_lk, m_err});
            end
            if (err === 1'b1) err_cnt++;
            if (locked !== 1'b1) unlocked++;
            if (f == 1 && p == 7) begin
               checks++;
               if (frame_valid !== 1'b0 || {out_ms, out_s, out_min} !== vf[0]) begin
                  failures++;
                  $display("FAIL glitch_hold got fv=%b out=%h want fv=0 out=%h", frame_valid, {out_ms, out_s, out_min}, vf[0]);
               end
            end
            if (f == 2 && p == 7) begin
               checks++;
               if (frame_valid !== 1'b1 || {out_ms, out_s, out_min} !== vf[2]) begin
                  failures++;
                  $display("FAIL glitch_recommit got fv=%b out=%h want fv=1 out=%h", frame_valid, {out_ms, out_s, out_min}, vf[2]);
               end
            end
         end
      end
      checks++;
      if (err_cnt != 1 || unlocked != 0) begin
         failures++;
         $display("FAIL glitch_err_lock got errs=%0d unlocked=%0d want errs=1 unlocked=0", err_cnt, unlocked);
      end
   endtask

   task automatic test_loss_of_lock();
      logic [23:0] vf [6];
      logic [3:0] n;
      int idx;
      int err_cnt = 0;
      int relock = -1;
      int recommit = -1;
      for (int f = 0; f < 6; f++) vf[f] = rand_time();
      for (int f = 0; f < 6; f++) begin
         for (int p = 0; p < 8; p++) begin
            idx = f * 8 + p;
            n = frame_nib(vf[f], sp);
            if (f < 2 && p == 5) n = 4'd3;
            src(n);
            checks++;
            if ({out_ms, out_s, out_min, frame_valid, locked, err} !== {m_out, m_fv, m_lk, m_err}) begin
               failures++;
               $display("FAIL loss_cycle idx=%0d got=%h want=%h", idx, {out_ms, out_s, out_min, frame_valid, locked, err}, {m_out, m_fv, m_lk, m_err});
            end
            if (err === 1'b1) err_cnt++;
            if (idx == 14 || idx == 15) begin
               checks++;
               if (locked !== (idx == 14)) begin
                  failures++;
                  $display("FAIL loss_lock_fall idx=%0d got locked=%b want=%b", idx, locked, idx == 14);
               end
            end
            if (idx > 15 && locked === 1'b1 && relock < 0) relock = idx;
            if (idx > 15 && frame_valid === 1'b1 && recommit < 0) begin
               recommit = idx;
               checks++;
               if ({out_ms, out_s, out_min} !== vf[3]) begin
                  failures++;
                  $display("FAIL loss_recommit_val got=%h want=%h", {out_ms, out_s, out_min}, vf[3]);
               end
            end
         end
      end
      checks++;
      if (err_cnt != 2 || relock != 26 || recommit != 31) begin
         failures++;
         $display("FAIL loss_reacquire got errs=%0d relock=%0d commit=%0d want errs=2 relock=26 commit=31", err_cnt, relock, recommit);
      end
   endtask

   task automatic test_rollover();
      logic [23:0] vf [6];
      vf[0] = 24'h995959;
      vf[1] = 24'h000000;
      vf[2] = 24'h995959;
      vf[3] = 24'h000000;
      vf[4] = rand_time();
      vf[5] = rand_time();
      for (int f = 0; f < 6; f++) begin
         for (int p = 0; p < 8; p++) begin
            src(frame_nib(vf[f], sp));
            checks++;
            if ({out_ms, out_s, out_min, frame_valid, locked, err} !== {m_out, m_fv, m_lk, m_err}) begin
               failures++;
               $display("FAIL rollover_cycle f=%0d p=%0d got=%h want=%h", f, p, {out_ms, out_s, out_min, frame_valid, locked, err}, {m_out, m_fv, m_lk, m_err});
            end
            if (p == 7) begin
               checks++;
               if (frame_valid !== 1'b1 || {out_ms, out_s, out_min} !== vf[f]) begin
                  failures++;
                  $display("FAIL rollover_commit f=%0d got fv=%b out=%h want fv=1 out=%h", f, frame_valid, {out_ms, out_s, out_min}, vf[f]);
               end
            end
         end
      end
   endtask

   task automatic test_random_errors();
      logic [23:0] v;
      logic [3:0] n;
      for (int f = 0; f < 40; f++) begin
         v = rand_time();
         for (int p = 0; p < 8; p++) begin
            n = frame_nib(v, sp);
            if ($urandom_range(0, 31) == 0) n = 4'($urandom_range(0, 15));
            src(n);
            checks++;
            if ({out_ms, out_s, out_min, frame_valid, locked, err} !== {m_out, m_fv, m_lk, m_err}) begin
               failures++;
               $display("FAIL random_cycle f=%0d p=%0d got=%h want=%h", f, p, {out_ms, out_s, out_min, frame_valid, locked, err}, {m_out, m_fv, m_lk, m_err});
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [23:0] v = rand_time();
      int first_lock = -1;
      int first_fv = -1;
      pulse_reset();
      sp = 0;
      for (int s = 0; s < 28; s++) src(frame_nib(v, sp));
      checks++;
      if (locked !== 1'b1 || {out_ms, out_s, out_min} !== v) begin
         failures++;
         $display("FAIL rstmid_prelock got locked=%b out=%h want locked=1 out=%h", locked, {out_ms, out_s, out_min}, v);
      end
      rst = 1'b1;
      inc = frame_nib(v, sp);
      @(posedge clkc);
      #1;
      rst = 1'b0;
      model_reset();
      sp = (sp + 1) % 8;
      checks++;
      if ({out_ms, out_s, out_min, frame_valid, locked, err} !== 27'd0) begin
         failures++;
         $display("FAIL rstmid_clear got=%h want=0", {out_ms, out_s, out_min, frame_valid, locked, err});
      end
      for (int s = 1; s <= 32; s++) begin
         src(frame_nib(v, sp));
         checks++;
         if ({out_ms, out_s, out_min, frame_valid, locked, err} !== {m_out, m_fv, m_lk, m_err}) begin
            failures++;
            $display("FAIL rstmid_cycle s=%0d got=%h want=%h", s, {out_ms, out_s, out_min, frame_valid, locked, err}, {m_out, m_fv, m_lk, m_err});
         end
         if (locked === 1'b1 && first_lock < 0) first_lock = s;
         if (frame_valid === 1'b1 && first_fv < 0) first_fv = s;
      end
      checks++;
      if (first_lock != 14 || first_fv != 19) begin
         failures++;
         $display("FAIL rstmid_reacquire got lock=%0d commit=%0d want lock=14 commit=19", first_lock, first_fv);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_acquisition();
      test_mid_frame();
      test_glitch();
      test_loss_of_lock();
      test_rollover();
      test_random_errors();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
